// File: rtl/mux_arb_pkg.sv
// Shared constants and FSM encoding for the 16-way round-robin operand arbiter.
package mux_arb_pkg;
  localparam int NUM_REQ   = 16;
  localparam int SEL_W     = 4;
  localparam int DEF_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_e;
endpackage

// File: rtl/mux_16to1_arbiter_if.sv
// Requester/consumer bundle of the round-robin arbiter.
// req_lock exists only when MUX_ARB_LOCK_EN is defined.
import mux_arb_pkg::*;

interface mux_16to1_arbiter_if #(parameter int WIDTH = DEF_WIDTH);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
`ifdef MUX_ARB_LOCK_EN
  logic [NUM_REQ-1:0]       req_lock;
`endif
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  logic [SEL_W-1:0]         out_sel;
  logic                     out_ready;

  modport master (
    output req_valid, req_data, out_ready,
`ifdef MUX_ARB_LOCK_EN
    output req_lock,
`endif
    input  req_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  req_valid, req_data, out_ready,
`ifdef MUX_ARB_LOCK_EN
    input  req_lock,
`endif
    output req_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/mux_16to1.sv
// Plain 16:1 WIDTH-bit combinational multiplexer, S selects A..P.
module mux_16to1 #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] A, B, C, D, E, F, G, H,
  input  logic [WIDTH-1:0] I, J, K, L, M, N, O, P,
  input  logic [3:0]       S,
  output logic [WIDTH-1:0] Y
);
  always_comb begin
    Y = A;
    case (S)
      4'd0:  Y = A;
      4'd1:  Y = B;
      4'd2:  Y = C;
      4'd3:  Y = D;
      4'd4:  Y = E;
      4'd5:  Y = F;
      4'd6:  Y = G;
      4'd7:  Y = H;
      4'd8:  Y = I;
      4'd9:  Y = J;
      4'd10: Y = K;
      4'd11: Y = L;
      4'd12: Y = M;
      4'd13: Y = N;
      4'd14: Y = O;
      default: Y = P;
    endcase
  end
endmodule

// File: rtl/mux_16to1_arbiter.sv
// Round-robin arbiter sharing one mux_16to1 among 16 requesters, registered valid/ready output.
// MUX_ARB_LOCK_EN: req_lock keeps the winner at top priority for a burst.
import mux_arb_pkg::*;

module mux_16to1_arbiter #(parameter int WIDTH = DEF_WIDTH) (
  input logic               clk,
  input logic               rst,
  mux_16to1_arbiter_if.slave bus
);
  arb_state_e state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt, win;
  logic             any, accept, grant;
  logic [WIDTH-1:0] mux_y, data_q;
  logic [SEL_W-1:0] sel_q;
  logic [NUM_REQ-1:0][WIDTH-1:0] slice;

  assign slice = bus.req_data;

  // First valid index scanning upward from ptr with wraparound.
  always_comb begin : search
    logic [SEL_W-1:0] idx;
    idx = '0;
    win = '0;
    any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + SEL_W'(k);
      if (!any && bus.req_valid[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end

  assign accept = (state == IDLE) || bus.out_ready;
  assign grant  = accept && any && !rst;
  assign bus.req_ready = grant ? (NUM_REQ'(1) << win) : '0;

  mux_16to1 #(.WIDTH(WIDTH)) u_mux (
    .A(slice[0]),  .B(slice[1]),  .C(slice[2]),  .D(slice[3]),
    .E(slice[4]),  .F(slice[5]),  .G(slice[6]),  .H(slice[7]),
    .I(slice[8]),  .J(slice[9]),  .K(slice[10]), .L(slice[11]),
    .M(slice[12]), .N(slice[13]), .O(slice[14]), .P(slice[15]),
    .S(win),
    .Y(mux_y)
  );

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    if (accept) begin
      if (any) begin
        state_nxt = SEND;
`ifdef MUX_ARB_LOCK_EN
        ptr_nxt = bus.req_lock[win] ? win : win + SEL_W'(1);
`else
        ptr_nxt = win + SEL_W'(1);
`endif
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      sel_q  <= '0;
    end else if (accept && any) begin
      data_q <= mux_y;
      sel_q  <= win;
    end
  end

  assign bus.out_valid = (state == SEND);
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
endmodule

// File: tb/tb_mux_16to1_arbiter.sv
// Directed + random bench for mux_16to1_arbiter against a priority-distance reference model.
module tb_mux_16to1_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_16to1_arbiter_if #(.WIDTH(W)) bus();
  mux_16to1_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total  = 0;
  int passed = 0;

  logic [W-1:0] data [16];
  logic         m_valid;
  logic [3:0]   m_sel;
  logic [W-1:0] m_data;
  int           m_ptr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Winner is the valid requester at the smallest rotational distance from ptr.
  function automatic int rr_pick(input logic [15:0] rv, input int p);
    int best, bestd;
    best = -1; bestd = 99;
    for (int i = 0; i < 16; i++)
      if (rv[i] && ((i - p + 16) % 16) < bestd) begin
        bestd = (i - p + 16) % 16;
        best  = i;
      end
    return best;
  endfunction

  task automatic drive_data();
    for (int i = 0; i < 16; i++) bus.req_data[i*W +: W] = data[i];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 16'hFFFF;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_sel",   64'(bus.out_sel),   64'd0);
    chk("rst_out_data",  64'(bus.out_data),  64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid = '0;
    bus.out_ready = 1'b0;
    m_valid = 1'b0; m_sel = '0; m_data = '0; m_ptr = 0;
  endtask

  task automatic step(input logic [15:0] rv, input logic ordy, input logic [15:0] lk);
    logic [15:0] exp_rdy;
    logic        acc, use_lock;
    int          w;
    bus.req_valid = rv;
    bus.out_ready = ordy;
`ifdef MUX_ARB_LOCK_EN
    bus.req_lock = lk;
`endif
    drive_data();
    @(negedge clk);
    acc = !m_valid || ordy;
    w   = rr_pick(rv, m_ptr);
    exp_rdy = (acc && w >= 0) ? (16'd1 << w) : 16'd0;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    @(posedge clk); #1;
    if (acc) begin
      if (w >= 0) begin
`ifdef MUX_ARB_LOCK_EN
        use_lock = lk[w];
`else
        use_lock = 1'b0;
`endif
        m_valid = 1'b1; m_sel = 4'(w); m_data = data[w];
        m_ptr = use_lock ? w : (w + 1) % 16;
      end else m_valid = 1'b0;
    end
    chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
    if (m_valid) begin
      chk("out_sel",  64'(bus.out_sel),  64'(m_sel));
      chk("out_data", 64'(bus.out_data), 64'(m_data));
    end
  endtask

  initial begin
    bus.req_valid = '0; bus.req_data = '0; bus.out_ready = 1'b0;
`ifdef MUX_ARB_LOCK_EN
    bus.req_lock = '0;
`endif
    for (int i = 0; i < 16; i++) data[i] = W'(i);
    #2;
    do_reset();

    // single request, then ptr=5 makes 3 beat 4
    step(16'h0010, 1'b0, '0);
    chk("single_sel", 64'(bus.out_sel), 64'd4);
    chk("single_data", 64'(bus.out_data), 64'h4);
    step(16'h0018, 1'b1, '0);
    chk("ptr5_sel", 64'(bus.out_sel), 64'd3);

    // full load round robin
    do_reset();
    for (int k = 0; k < 17; k++) begin
      step(16'hFFFF, 1'b1, '0);
      chk("rr_sel", 64'(bus.out_sel), 64'(k % 16));
    end

    // backpressure on sel 7
    do_reset();
    step(16'h0080, 1'b0, '0);
    for (int k = 0; k < 5; k++) begin
      step(16'hFFFF, 1'b0, '0);
      chk("bp_sel", 64'(bus.out_sel), 64'd7);
      chk("bp_data", 64'(bus.out_data), 64'd7);
    end
    step(16'hFFFF, 1'b1, '0);
    chk("bp_release_sel", 64'(bus.out_sel), 64'd8);

    // wrap: ptr=15, 0 before 14
    do_reset();
    step(16'h4000, 1'b1, '0);
    step(16'h4001, 1'b1, '0);
    chk("wrap_sel0", 64'(bus.out_sel), 64'd0);
    do_reset();
    step(16'h4000, 1'b1, '0);
    step(16'h4000, 1'b1, '0);
    chk("wrap_sel14", 64'(bus.out_sel), 64'd14);

    // asynchronous reset while holding sel 9
    do_reset();
    step(16'h0200, 1'b0, '0);
    chk("pre_rst_sel", 64'(bus.out_sel), 64'd9);
    bus.out_ready = 1'b0;
    #2;
    do_reset();
    step(16'h0000, 1'b1, '0);

`ifdef MUX_ARB_LOCK_EN
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(16'h0006, 1'b1, 16'h0002);
      chk("lock_sel1", 64'(bus.out_sel), 64'd1);
    end
    step(16'h0006, 1'b1, 16'h0000);
    chk("unlock_sel1", 64'(bus.out_sel), 64'd1);
    step(16'h0006, 1'b1, 16'h0000);
    chk("unlock_sel2", 64'(bus.out_sel), 64'd2);
`endif

    // random traffic with random backpressure and requesters coming and going
    do_reset();
    for (int k = 0; k < 400; k++) begin
      logic [15:0] rv, lk;
      for (int i = 0; i < 16; i++) data[i] = $urandom;
      rv = 16'($urandom);
      if ($urandom_range(0, 1) == 0) rv = rv & 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 9) == 0) rv = '0;
      lk = 16'($urandom) & 16'($urandom);
      step(rv, ($urandom_range(0, 3) != 0), lk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
